// File: rtl/sobig_divider.sv
// Bit-serial restoring divider for sign-magnitude fixed-point operands: quotient = num2 / num1 with FRAC_OUT fractional bits.
// One quotient bit per clock. Inputs are sampled once in LOAD. The result is sticky in DONE until the next init pulse.
module sobig_divider #(
  parameter int FRAC_OUT = 32,
  parameter int MAXSHIFT = 159
) (
  input  logic        systclk,
  input  logic        init,
  input  logic [64:0] num1,
  input  logic [64:0] num2,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [6:0]  dotplace1,
  input  logic [6:0]  dotplace2,
  input  logic [6:0]  deltadotplace,
  output logic [63:0] result,
  output logic        signresult,
  output logic [6:0]  dotplaceresult,
  output logic        calcover
);

  localparam int CW = $clog2(65 + MAXSHIFT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t         state, state_nxt;
  logic [64:0]    dvd;
  logic [64:0]    dvs;
  logic [65:0]    rem;
  logic [63:0]    quot;
  logic           ovf;
  logic           sgn;
  logic [CW-1:0]  cnt;

  logic [8:0]     lpos;
  logic [6:0]     rshift;
  logic [CW-1:0]  nsteps;
  logic [65:0]    rem_sh;
  logic [65:0]    rem_sub;
  logic           qbit;

  // Positive L appends zero bits to the dividend; negative L pre-shifts num2 right instead.
  always_comb begin
    lpos   = '0;
    rshift = '0;
    if (dotplace1 >= dotplace2)
      lpos = 9'(FRAC_OUT) + {2'b00, deltadotplace};
    else if (deltadotplace <= 7'(FRAC_OUT))
      lpos = 9'(FRAC_OUT) - {2'b00, deltadotplace};
    else
      rshift = deltadotplace - 7'(FRAC_OUT);
    nsteps = CW'(65) + CW'(lpos);
  end

  always_comb begin
    rem_sh  = {rem[64:0], dvd[64]};
    qbit    = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge systclk or posedge init) begin
    if (init)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    state_nxt = (num1 == '0) ? DONE : DIV;
      DIV:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge systclk or posedge init) begin
    if (init) begin
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      quot <= '0;
      ovf  <= 1'b0;
      sgn  <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          dvs  <= num1;
          dvd  <= num2 >> rshift;
          rem  <= '0;
          quot <= '0;
          ovf  <= (num1 == '0);
          sgn  <= sign1 ^ sign2;
          cnt  <= nsteps;
        end
        DIV: begin
          dvd  <= {dvd[63:0], 1'b0};
          rem  <= qbit ? rem_sub : rem_sh;
          quot <= {quot[62:0], qbit};
          ovf  <= ovf | quot[63];
          cnt  <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    calcover       = (state == DONE);
    result         = calcover ? (ovf ? '1 : quot) : '0;
    signresult     = calcover & sgn;
    dotplaceresult = calcover ? 7'(FRAC_OUT) : '0;
  end

endmodule

// File: tb/tb_sobig_divider.sv
// Scoreboarded bench for sobig_divider: expected results are queued as each division is started and checked when calcover rises.
module tb_sobig_divider;

  logic        systclk = 1'b0;
  logic        init;
  logic [64:0] num1, num2;
  logic        sign1, sign2;
  logic [6:0]  dotplace1, dotplace2, deltadotplace;
  logic [63:0] result;
  logic        signresult;
  logic [6:0]  dotplaceresult;
  logic        calcover;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    logic        sgn;
    int          lat;
  } exp_t;

  exp_t sb[$];

  sobig_divider dut (
    .systclk(systclk), .init(init), .num1(num1), .num2(num2),
    .sign1(sign1), .sign2(sign2), .dotplace1(dotplace1), .dotplace2(dotplace2),
    .deltadotplace(deltadotplace), .result(result), .signresult(signresult),
    .dotplaceresult(dotplaceresult), .calcover(calcover)
  );

  always #5 systclk = ~systclk;

  function automatic exp_t model(input logic [64:0] n1, input logic [64:0] n2,
                                 input logic s1, input logic s2, input int dp1, input int dp2);
    exp_t e;
    int l;
    logic [287:0] dd, q;
    l  = 32 + dp1 - dp2;
    dd = {223'b0, n2};
    if (l >= 0) dd = dd << l;
    else        dd = dd >> (-l);
    e.sgn = s1 ^ s2;
    if (n1 == 0) begin
      e.res = '1;
      e.lat = 2;
    end else begin
      q     = dd / {223'b0, n1};
      e.res = (q[287:64] != 0) ? '1 : q[63:0];
      e.lat = 65 + ((l > 0) ? l : 0) + 2;
    end
    return e;
  endfunction

  // Pulses init, applies operands, counts edges to calcover, then scrambles inputs after LOAD.
  task automatic do_op(input logic [64:0] n1, input logic [64:0] n2, input logic s1, input logic s2,
                       input int dp1, input int dp2,
                       output logic [63:0] r, output logic s, output logic [6:0] d,
                       output int lat, output logic early);
    logic done;
    @(negedge systclk);
    init = 1'b1;
    num1 = n1; num2 = n2; sign1 = s1; sign2 = s2;
    dotplace1 = 7'(dp1); dotplace2 = 7'(dp2);
    deltadotplace = (dp1 >= dp2) ? 7'(dp1 - dp2) : 7'(dp2 - dp1);
    @(negedge systclk);
    init  = 1'b0;
    lat   = 0;
    early = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge systclk); #1;
      lat++;
      if (calcover === 1'b1) done = 1'b1;
      else begin
        if (result !== '0 || signresult !== 1'b0 || dotplaceresult !== '0) early = 1'b1;
        if (lat == 2) begin
          num1 = {$urandom_range(1, 0), $urandom, $urandom};
          num2 = {$urandom_range(1, 0), $urandom, $urandom};
          sign1 = ~s1; sign2 = s2;
          dotplace1 = 7'($urandom_range(127, 0));
          dotplace2 = 7'($urandom_range(127, 0));
          deltadotplace = 7'($urandom_range(127, 0));
        end
      end
    end
    if (!done) lat = -1;
    r = result; s = signresult; d = dotplaceresult;
  endtask

  task automatic test_reset();
    init = 1'b1;
    num1 = 65'd1; num2 = 65'd1; sign1 = 1'b1; sign2 = 1'b0;
    dotplace1 = '0; dotplace2 = '0; deltadotplace = '0;
    repeat (3) @(posedge systclk);
    #1;
    checks++; if (calcover !== 1'b0) begin errors++; $display("FAIL reset_calcover got %b exp 0", calcover); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (signresult !== 1'b0) begin errors++; $display("FAIL reset_sign got %b exp 0", signresult); end
    checks++; if (dotplaceresult !== 7'd0) begin errors++; $display("FAIL reset_dotplace got %0d exp 0", dotplaceresult); end
  endtask

  task automatic test_directed();
    logic [64:0] n1[7], n2[7];
    logic s1[7], s2[7];
    int p1[7], p2[7];
    exp_t ev[7];
    logic [63:0] r; logic s; logic [6:0] d; int lat; logic early; exp_t e;
    // 0.5/1.0, 3.0/1.0, sign+point mismatch, divide by zero, overflow, zero dividend, max shift
    n2[0] = 65'd1 << 52;     n1[0] = 65'd1 << 53; s1[0] = 0; s2[0] = 0; p1[0] = 53;  p2[0] = 53;
    ev[0] = '{64'h0000_0000_8000_0000, 1'b0, 99};
    n2[1] = 65'd3 << 53;     n1[1] = 65'd1 << 53; s1[1] = 0; s2[1] = 0; p1[1] = 53;  p2[1] = 53;
    ev[1] = '{64'h0000_0003_0000_0000, 1'b0, 99};
    n2[2] = 65'd6;           n1[2] = 65'd48;      s1[2] = 0; s2[2] = 1; p1[2] = 4;   p2[2] = 0;
    ev[2] = '{64'h0000_0002_0000_0000, 1'b1, 103};
    n2[3] = 65'd5;           n1[3] = 65'd0;       s1[3] = 1; s2[3] = 0; p1[3] = 10;  p2[3] = 3;
    ev[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2};
    n2[4] = 65'd1 << 64;     n1[4] = 65'd1;       s1[4] = 0; s2[4] = 0; p1[4] = 0;   p2[4] = 0;
    ev[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 99};
    n2[5] = 65'd0;           n1[5] = 65'd7;       s1[5] = 0; s2[5] = 1; p1[5] = 0;   p2[5] = 0;
    ev[5] = '{64'h0, 1'b1, 99};
    n2[6] = 65'd1;           n1[6] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}; s1[6] = 1; s2[6] = 1; p1[6] = 127; p2[6] = 0;
    ev[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 226};
    for (int k = 0; k < 7; k++) begin
      sb.push_back(ev[k]);
      do_op(n1[k], n2[k], s1[k], s2[k], p1[k], p2[k], r, s, d, lat, early);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL directed%0d_result got %h exp %h", k, r, e.res); end
      checks++; if (s !== e.sgn) begin errors++; $display("FAIL directed%0d_sign got %b exp %b", k, s, e.sgn); end
      checks++; if (d !== 7'd32) begin errors++; $display("FAIL directed%0d_dotplace got %0d exp 32", k, d); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL directed%0d_latency got %0d exp %0d", k, lat, e.lat); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL directed%0d_early_output got %b exp 0", k, early); end
    end
  endtask

  task automatic test_neg_shift();
    logic [63:0] r; logic s; logic [6:0] d; int lat; logic early; exp_t e;
    logic [64:0] n2v;
    n2v = {1'b1, 64'h2345_6789_ABCD_EF00};
    sb.push_back(model(65'd3, n2v, 1'b1, 1'b0, 0, 40));
    do_op(65'd3, n2v, 1'b1, 1'b0, 0, 40, r, s, d, lat, early);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL neg_shift_result got %h exp %h", r, e.res); end
    checks++; if (s !== e.sgn) begin errors++; $display("FAIL neg_shift_sign got %b exp %b", s, e.sgn); end
    checks++; if (lat != 67) begin errors++; $display("FAIL neg_shift_latency got %0d exp 67", lat); end
  endtask

  task automatic test_reset_mid_div();
    logic [63:0] r; logic s; logic [6:0] d; int lat; logic early; exp_t e;
    @(negedge systclk);
    init = 1'b1;
    num1 = 65'd1 << 53; num2 = 65'd3 << 53; sign1 = 1'b0; sign2 = 1'b0;
    dotplace1 = 7'd53; dotplace2 = 7'd53; deltadotplace = 7'd0;
    @(negedge systclk);
    init = 1'b0;
    repeat (22) @(posedge systclk);
    #1;
    checks++; if (calcover !== 1'b0) begin errors++; $display("FAIL mid_div_busy got %b exp 0", calcover); end
    @(negedge systclk);
    init = 1'b1;
    #1;
    checks++; if (calcover !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL mid_div_abort got calcover %b result %h exp 0 0", calcover, result);
    end
    sb.push_back('{64'h0000_0003_0000_0000, 1'b0, 99});
    do_op(65'd1 << 53, 65'd3 << 53, 1'b0, 1'b0, 53, 53, r, s, d, lat, early);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL mid_div_restart_result got %h exp %h", r, e.res); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL mid_div_restart_latency got %0d exp %0d", lat, e.lat); end
    // Async clear from DONE, no clock edge in between
    #2;
    init = 1'b1;
    #1;
    checks++; if (calcover !== 1'b0 || result !== '0 || dotplaceresult !== '0) begin
      errors++; $display("FAIL async_clear got calcover %b result %h dp %0d exp 0 0 0", calcover, result, dotplaceresult);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; logic s; logic [6:0] d; int lat; logic early; exp_t e;
    logic [64:0] n1, n2; logic s1, s2; int dp1, dp2;
    for (int k = 0; k < 24; k++) begin
      n2  = {$urandom_range(1, 0), $urandom, $urandom};
      n1  = {$urandom_range(1, 0), $urandom, $urandom} >> $urandom_range(64, 0);
      s1  = $urandom_range(1, 0);
      s2  = $urandom_range(1, 0);
      dp1 = $urandom_range(70, 0);
      dp2 = $urandom_range(70, 0);
      sb.push_back(model(n1, n2, s1, s2, dp1, dp2));
      do_op(n1, n2, s1, s2, dp1, dp2, r, s, d, lat, early);
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL rand%0d_result got %h exp %h", k, r, e.res); end
      checks++; if (s !== e.sgn) begin errors++; $display("FAIL rand%0d_sign got %b exp %b", k, s, e.sgn); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", k, lat, e.lat); end
    end
  endtask

  initial begin
    init = 1'b1;
    num1 = '0; num2 = '0; sign1 = 1'b0; sign2 = 1'b0;
    dotplace1 = '0; dotplace2 = '0; deltadotplace = '0;
    test_reset();
    test_directed();
    test_neg_shift();
    test_reset_mid_div();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
